// File: rtl/bk_pkg.sv
`default_nettype none
// ============================================================================
// Package     : bk_pkg
// Description : Shared types and helpers for the Brent-Kung adder family.
//               gp_t carries a generate/propagate pair; gp_combine is the
//               prefix operator (hi o lo); bk_levels gives ceil(log2(width)).
// Revision    : 1.0 - initial release
// ============================================================================
package bk_pkg;

  localparam int WIDTH_DEFAULT = 12;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // ceil(log2(width)); 0 for width <= 1.
  function automatic int bk_levels(input int width);
    int lv;
    lv = 0;
    while ((1 << lv) < width) lv++;
    return lv;
  endfunction

  // Group (hi) absorbing the lower group (lo): standard carry-prefix operator.
  function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bk_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : bk_pipe_stage
// Description : Generic valid/ready register slice. Accepts a beat whenever
//               it is empty or its current beat leaves this cycle; payload is
//               only written on an accepted beat so it holds while stalled.
// Revision    : 1.0 - initial release
// Ports       :
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset (clears valid and payload)
//   in_valid   in   upstream beat present
//   in_ready   out  slice can take a beat this cycle
//   in_data    in   upstream payload
//   out_valid  out  slice holds a beat
//   out_ready  in   downstream takes the beat
//   out_data   out  registered payload
// ============================================================================
module bk_pipe_stage
  import bk_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  // Combinational ready chain: a full slice still accepts if it drains now.
  assign in_ready  = ~valid_q | out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) data_q <= in_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bk_sum_decoder.sv
`default_nettype none
// ============================================================================
// Module      : bk_sum_decoder
// Description : Recovers operand B = SUM - A from a (WIDTH+1)-bit adder result
//               and one WIDTH-bit operand, flagging sums that no WIDTH-bit B
//               could produce. SUM - A is computed as SUM + ~A + 1 over
//               WIDTH+1 bits with a 3-stage Brent-Kung prefix pipeline:
//               S1 bit g/p, S2 up-sweep, S3 down-sweep + difference.
// Revision    : 1.0 - initial release
// Ports       :
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   input beat present
//   in_ready   out  beat accepted this cycle (combinational from out_ready)
//   in_sum     in   adder result, bit WIDTH is the carry out
//   in_a       in   known operand
//   out_valid  out  result beat present
//   out_ready  in   downstream accepts result
//   out_b      out  (in_sum - in_a) mod 2^WIDTH
//   out_err    out  in_sum < in_a or in_sum - in_a > 2^WIDTH-1
//   busy       out  any stage holds a beat
// ============================================================================
module bk_sum_decoder
  import bk_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEFAULT,
  parameter int STAGES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   in_sum,
  input  logic [WIDTH-1:0] in_a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_b,
  output logic             out_err,
  output logic             busy
);

  localparam int N      = WIDTH + 1;     // prefix network width
  localparam int LEVELS = bk_levels(N);
  localparam int S1_W   = 2 * WIDTH + 1; // bit g/p pairs + sum MSB
  localparam int S2_W   = 3 * N;         // original p bits + up-swept nodes
  localparam int S3_W   = WIDTH + 1;     // {err, b}

  generate
    if (STAGES != 3) begin : g_bad_stages
      $error("bk_sum_decoder: STAGES must be 3");
    end
  endgenerate

  logic            v1, v2, v3;
  logic            rdy2, rdy3;
  logic [S1_W-1:0] s1_din, s1_dout;
  logic [S2_W-1:0] s2_din, s2_dout;
  logic [S3_W-1:0] s3_din, s3_dout;

  // ---------------- S1: per-bit generate/propagate of SUM + ~A ----------------
  gp_t [WIDTH-1:0] bit_gp;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      bit_gp[i].g = in_sum[i] & ~in_a[i];
      bit_gp[i].p = in_sum[i] ^ ~in_a[i];
    end
  end

  // Bit WIDTH has a=0, so its g/p are rebuilt from the stored sum MSB in S2.
  assign s1_din = {in_sum[WIDTH], bit_gp};

  // ---------------- S2: Brent-Kung up-sweep ----------------
  gp_t [WIDTH-1:0] s1_gp;
  logic            s1_msb;
  gp_t [N-1:0]     up;
  logic [N-1:0]    p_bits;

  assign s1_gp  = s1_dout[2*WIDTH-1:0];
  assign s1_msb = s1_dout[2*WIDTH];

  always_comb begin
    up = {{s1_msb, ~s1_msb}, s1_gp};
    for (int i = 0; i < N; i++) p_bits[i] = up[i].p;
    // The +1 carry-in is folded into bit 0 so every prefix G is a true carry.
    up[0].g = up[0].g | up[0].p;
    for (int l = 0; l < LEVELS; l++) begin
      for (int i = (2 << l) - 1; i < N; i += (2 << l)) begin
        up[i] = gp_combine(up[i], up[i - (1 << l)]);
      end
    end
  end

  assign s2_din = {p_bits, up};

  // ---------------- S3: down-sweep, carries, difference ----------------
  gp_t [N-1:0]  dn;
  logic [N-1:0] s2_p;
  logic [N-1:0] carry;
  logic [N-1:0] diff;
  logic         no_borrow;

  assign s2_p = s2_dout[S2_W-1:2*N];

  always_comb begin
    dn = s2_dout[2*N-1:0];
    for (int l = LEVELS - 1; l >= 0; l--) begin
      for (int i = 3 * (1 << l) - 1; i < N; i += (2 << l)) begin
        dn[i] = gp_combine(dn[i], dn[i - (1 << l)]);
      end
    end
    carry[0] = 1'b1;
    for (int i = 1; i < N; i++) carry[i] = dn[i-1].g;
    diff      = s2_p ^ carry;
    no_borrow = dn[N-1].g;
  end

  // A borrow means SUM < A; a set diff MSB means the difference exceeds WIDTH bits.
  assign s3_din = {~no_borrow | diff[WIDTH], diff[WIDTH-1:0]};

  // ---------------- Register slices ----------------
  bk_pipe_stage #(.DATA_W(S1_W)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_din),
    .out_valid (v1),
    .out_ready (rdy2),
    .out_data  (s1_dout)
  );

  bk_pipe_stage #(.DATA_W(S2_W)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v1),
    .in_ready  (rdy2),
    .in_data   (s2_din),
    .out_valid (v2),
    .out_ready (rdy3),
    .out_data  (s2_dout)
  );

  bk_pipe_stage #(.DATA_W(S3_W)) u_s3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v2),
    .in_ready  (rdy3),
    .in_data   (s3_din),
    .out_valid (v3),
    .out_ready (out_ready),
    .out_data  (s3_dout)
  );

  assign out_valid = v3;
  assign out_b     = s3_dout[WIDTH-1:0];
  assign out_err   = s3_dout[WIDTH];
  assign busy      = v1 | v2 | v3;

endmodule
`default_nettype wire

// File: tb/tb_bk_sum_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bk_sum_decoder
// Description : Directed self-checking bench for bk_sum_decoder: reset state,
//               single beats with latency, boundary vectors, a stalled
//               10-beat stream, mid-flight reset and constructed random pairs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bk_sum_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] in_sum;
  logic [11:0] in_a;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_b;
  logic        out_err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bk_sum_decoder #(.WIDTH(12), .STAGES(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_a      (in_a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_b     (out_b),
    .out_err   (out_err),
    .busy      (busy)
  );

  // Hand-computed vectors: sum, a -> b, err
  logic [12:0] vs [10] = '{13'd300, 13'd5, 13'd0, 13'd8190, 13'd8191,
                           13'd4096, 13'd1000, 13'd4095, 13'd4096, 13'd0};
  logic [11:0] va [10] = '{12'd100, 12'd9, 12'd0, 12'd4095, 12'd0,
                           12'd1, 12'd1000, 12'd0, 12'd0, 12'd1};
  logic [11:0] vb [10] = '{12'd200, 12'hFFC, 12'd0, 12'd4095, 12'd4095,
                           12'd4095, 12'd0, 12'd4095, 12'd0, 12'hFFF};
  logic        ve [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                           1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One beat into an empty pipe with out_ready held high.
  task automatic run_beat(input logic [12:0] s, input logic [11:0] a,
                          input logic [11:0] eb, input logic ee,
                          input string tag, input bit chk_lat);
    int lat;
    in_sum    = s;
    in_a      = a;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();                       // accept edge
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    if (chk_lat) check({tag, "_latency"}, 32'(lat), 32'd3);
    check({tag, "_b"},   32'(out_b),   32'(eb));
    check({tag, "_err"}, 32'(out_err), 32'(ee));
    tick();                       // result consumed
  endtask

  int          sent, recv, cyc;
  logic        acc, emit;
  logic [12:0] rs, rd;
  logic [11:0] ra, rb;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset ----
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_sum = '0; in_a = '0;
    repeat (2) tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_out_b",     32'(out_b),     32'd0);
    check("rst_out_err",   32'(out_err),   32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);

    // ---- single beats: first with latency, then every table vector ----
    run_beat(vs[0], va[0], vb[0], ve[0], "lat_300_100", 1'b1);
    for (int k = 1; k < 10; k++)
      run_beat(vs[k], va[k], vb[k], ve[k], $sformatf("vec%0d", k), 1'b0);

    // ---- stream 10 beats, out_ready low during cycles 4..8 ----
    sent = 0; recv = 0; cyc = 0;
    while (recv < 10 && cyc < 60) begin
      out_ready = !(cyc >= 4 && cyc <= 8);
      in_valid  = (sent < 10);
      if (sent < 10) begin
        in_sum = vs[sent];
        in_a   = va[sent];
      end
      #1;
      // Only a full pipe that cannot drain refuses input.
      check("stream_in_ready", 32'(in_ready), 32'(!((sent - recv) == 3 && !out_ready)));
      acc  = in_valid && in_ready;
      emit = out_valid && out_ready;
      if (out_valid && recv < 10) begin
        check(out_ready ? "stream_b" : "stall_hold_b",     32'(out_b),   32'(vb[recv]));
        check(out_ready ? "stream_err" : "stall_hold_err", 32'(out_err), 32'(ve[recv]));
      end else if (out_valid) begin
        check("stream_extra_beat", 32'(out_valid), 32'd0);
      end
      tick();
      sent += int'(acc);
      recv += int'(emit);
      cyc++;
    end
    in_valid = 1'b0;
    check("stream_sent", 32'(sent), 32'd10);
    check("stream_recv", 32'(recv), 32'd10);
    out_ready = 1'b1;
    tick();
    check("stream_drained_busy", 32'(busy), 32'd0);

    // ---- reset with two beats in flight ----
    out_ready = 1'b0;
    in_valid  = 1'b1; in_sum = vs[1]; in_a = va[1];
    tick();
    in_sum = vs[4]; in_a = va[4];
    tick();
    in_valid = 1'b0;
    check("midrst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy",      32'(busy),      32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("midrst_no_emit", 32'(out_valid), 32'd0);
    end
    run_beat(13'd300, 12'd100, 12'd200, 1'b0, "midrst_next", 1'b1);

    // ---- constructed pairs: sum = a + b must give back b without error ----
    for (int k = 0; k < 1500; k++) begin
      ra = 12'($urandom_range(0, 4095));
      rb = 12'($urandom_range(0, 4095));
      run_beat({1'b0, ra} + {1'b0, rb}, ra, rb, 1'b0, "rand_ab", 1'b0);
    end

    // ---- arbitrary (sum, a): error iff difference negative or > 4095 ----
    for (int k = 0; k < 1000; k++) begin
      rs = 13'($urandom_range(0, 8191));
      ra = 12'($urandom_range(0, 4095));
      rd = rs - {1'b0, ra};
      run_beat(rs, ra, rd[11:0], (rs < {1'b0, ra}) || (rd > 13'd4095), "rand_sa", 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
